// File: rtl/mc_array_ctrl.sv
// mc_array_ctrl: array command sequencer behind the AXI frame slave.
// Opens a row, streams column WR/RD per frame, closes it, refreshes.
module mc_array_ctrl #(
   parameter int AXI_ADDR_WIDTH  = 20,
   parameter int AXI_DATA_WIDTH  = 64,
   parameter int AXI_FRAME_WIDTH = AXI_ADDR_WIDTH + AXI_DATA_WIDTH + 3,
   parameter int T_RCD           = 2,
   parameter int T_WR            = 2,
   parameter int T_RP            = 2,
   parameter int T_RFC           = 8,
   parameter int T_REFI          = 512,
   parameter int RL              = 3
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       mc_en,
   input  logic [AXI_FRAME_WIDTH-1:0] axi_frame_data,
   input  logic                       axi_frame_valid,
   output logic                       axi_frame_ready,
   output logic [2:0]                 array_cmd,
   output logic [AXI_ADDR_WIDTH-7:0]  array_row,
   output logic [5:0]                 array_col,
   output logic [AXI_DATA_WIDTH-1:0]  array_wdata,
   input  logic [AXI_DATA_WIDTH-1:0]  array_dout,
   output logic [AXI_DATA_WIDTH-1:0]  array_rdata,
   output logic                       array_rvalid
);

   localparam int REF_W = $clog2(T_REFI);

   localparam logic [2:0] CMD_NOP = 3'd0;
   localparam logic [2:0] CMD_ACT = 3'd1;
   localparam logic [2:0] CMD_WR  = 3'd2;
   localparam logic [2:0] CMD_RD  = 3'd3;
   localparam logic [2:0] CMD_PRE = 3'd4;
   localparam logic [2:0] CMD_REF = 3'd5;

   // Wait-state reload values; the IDLE/PRE decision cycle is
   // part of each bound, so timings below 2 are not supported.
   localparam logic [7:0] LD_RCD = 8'(T_RCD - 2);
   localparam logic [7:0] LD_WR  = 8'(T_WR - 1);
   localparam logic [7:0] LD_RP  = 8'(T_RP - 2);
   localparam logic [7:0] LD_RFC = 8'(T_RFC - 2);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_RCD,
      S_ACCESS,
      S_WAIT_WR,
      S_PRE,
      S_WAIT_RP,
      S_WAIT_RFC
   } state_t;

   state_t            r_state, w_state_nxt;
   logic [7:0]        r_cnt, w_cnt_nxt;
   logic              r_first, w_first_nxt;
   logic              r_is_wr, w_is_wr_nxt;
   logic [2:0]        w_cmd;
   logic              w_ref_issue;
   logic              w_wr_sel;
   logic              w_hs;
   logic [REF_W-1:0]  r_ref_cnt;
   logic              r_ref_pend;
   logic              w_ref_wrap;
   logic [RL:0]       r_rd_pipe;

   logic                      w_sof, w_eof, w_rw;
   logic [AXI_ADDR_WIDTH-1:0] w_addr;
   logic [AXI_DATA_WIDTH-1:0] w_data;

   assign w_sof  = axi_frame_data[AXI_FRAME_WIDTH-1];
   assign w_eof  = axi_frame_data[AXI_FRAME_WIDTH-2];
   assign w_rw   = axi_frame_data[AXI_FRAME_WIDTH-3];
   assign w_addr = axi_frame_data[AXI_DATA_WIDTH +: AXI_ADDR_WIDTH];
   assign w_data = axi_frame_data[AXI_DATA_WIDTH-1:0];

   assign axi_frame_ready = (r_state == S_ACCESS);
   assign w_hs            = axi_frame_valid && axi_frame_ready;
   assign w_ref_wrap      = (r_ref_cnt == REF_W'(T_REFI - 1));

   // Next-state and command decision; command lands one cycle later.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_first_nxt = r_first;
      w_is_wr_nxt = r_is_wr;
      w_cmd       = CMD_NOP;
      w_ref_issue = 1'b0;
      w_wr_sel    = r_first ? w_rw : r_is_wr;
      unique case (r_state)
         S_IDLE: begin
            if (r_ref_pend) begin
               w_cmd       = CMD_REF;
               w_ref_issue = 1'b1;
               w_cnt_nxt   = LD_RFC;
               w_state_nxt = S_WAIT_RFC;
            end else if (mc_en && axi_frame_valid && w_sof) begin
               w_cmd       = CMD_ACT;
               w_cnt_nxt   = LD_RCD;
               w_first_nxt = 1'b1;
               w_state_nxt = S_WAIT_RCD;
            end
         end
         S_WAIT_RCD: begin
            if (r_cnt == 8'd0) w_state_nxt = S_ACCESS;
            else               w_cnt_nxt   = r_cnt - 8'd1;
         end
         S_ACCESS: begin
            if (w_hs) begin
               w_cmd       = w_wr_sel ? CMD_WR : CMD_RD;
               w_first_nxt = 1'b0;
               w_is_wr_nxt = w_wr_sel;
               if (w_eof) begin
                  if (w_wr_sel) begin
                     w_cnt_nxt   = LD_WR;
                     w_state_nxt = S_WAIT_WR;
                  end else begin
                     w_state_nxt = S_PRE;
                  end
               end
            end
         end
         S_WAIT_WR: begin
            if (r_cnt == 8'd0) w_state_nxt = S_PRE;
            else               w_cnt_nxt   = r_cnt - 8'd1;
         end
         S_PRE: begin
            w_cmd       = CMD_PRE;
            w_cnt_nxt   = LD_RP;
            w_state_nxt = S_WAIT_RP;
         end
         S_WAIT_RP, S_WAIT_RFC: begin
            if (r_cnt == 8'd0) w_state_nxt = S_IDLE;
            else               w_cnt_nxt   = r_cnt - 8'd1;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // FSM state, wait counter and latched burst type.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= 8'd0;
         r_first <= 1'b0;
         r_is_wr <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_first <= w_first_nxt;
         r_is_wr <= w_is_wr_nxt;
      end
   end

   // Registered command bus; address/data fields hold between commands.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         array_cmd   <= CMD_NOP;
         array_row   <= '0;
         array_col   <= '0;
         array_wdata <= '0;
      end else begin
         array_cmd <= w_cmd;
         if (w_cmd == CMD_ACT)
            array_row <= w_addr[AXI_ADDR_WIDTH-1:6];
         if (w_cmd == CMD_WR || w_cmd == CMD_RD)
            array_col <= w_addr[5:0];
         if (w_cmd == CMD_WR)
            array_wdata <= w_data;
      end
   end

   // Free-running refresh interval counter; a wrap arms one refresh.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ref_cnt  <= '0;
         r_ref_pend <= 1'b0;
      end else begin
         r_ref_cnt  <= w_ref_wrap ? '0 : r_ref_cnt + 1'b1;
         r_ref_pend <= w_ref_wrap | (r_ref_pend & ~w_ref_issue);
      end
   end

   // Read tracking pipe; stage RL lines up with array_dout.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_pipe    <= '0;
         array_rvalid <= 1'b0;
         array_rdata  <= '0;
      end else begin
         r_rd_pipe    <= {r_rd_pipe[RL-1:0], (w_cmd == CMD_RD)};
         array_rvalid <= r_rd_pipe[RL];
         if (r_rd_pipe[RL])
            array_rdata <= array_dout;
      end
   end

endmodule
